// File: rtl/alu_logical_issue.sv
// alu_logical_issue: valid/ready issue-and-collect controller wrapped around a registered logical ALU
module alu_logical_issue #(
  parameter int WIDTH = 16,
  parameter int LAT = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_opcode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [3:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] ops_count
);
  localparam int CW = $clog2(LAT + 1) + 1;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic legal;
  assign legal = req_opcode >= 4'b1000 && req_opcode <= 4'b1101;
  assign req_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
      ops_count <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          alu_opcode <= legal ? req_opcode : 4'b0;
          alu_a <= legal ? req_a : '0;
          alu_b <= legal ? req_b : '0;
          cnt <= CW'(LAT);
          // illegal opcodes bypass the ALU and answer immediately
          if (!legal) begin
            rsp_data <= '0;
            rsp_err <= 1'b1;
          end
          state <= legal ? WAIT : RESP;
        end
        WAIT: if (cnt != '0) cnt <= cnt - CW'(1);
        else begin
          rsp_data <= alu_out;
          rsp_err <= 1'b0;
          state <= RESP;
        end
        RESP: if (rsp_ready) begin
          ops_count <= ops_count + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_logical_issue.sv
// tb_alu_logical_issue: directed checks of the issue controller against a behavioural registered ALU
module tb_alu_logical_issue;
  logic clk = 0, rst = 1;
  logic req_valid = 0, rsp_ready = 0, req_ready, rsp_valid, rsp_err, busy;
  logic [3:0] req_opcode = 0, alu_opcode;
  logic [15:0] req_a = 0, req_b = 0, alu_a, alu_b, alu_out, rsp_data, ops_count;
  logic req_valid1 = 0, rsp_ready1 = 0, req_ready1, rsp_valid1, rsp_err1, busy1;
  logic [3:0] req_opcode1 = 0, alu_opcode1;
  logic [15:0] req_a1 = 0, req_b1 = 0, alu_a1, alu_b1, alu_out1, rsp_data1, p0, p1;
  logic [1:0] ops_count1;
  int tests = 0, fails = 0, n;
  always #5 clk = ~clk;

  alu_logical_issue #(.WIDTH(16), .LAT(1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy), .ops_count(ops_count));

  alu_logical_issue #(.WIDTH(16), .LAT(3), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_opcode(req_opcode1), .req_a(req_a1), .req_b(req_b1),
    .alu_opcode(alu_opcode1), .alu_a(alu_a1), .alu_b(alu_b1), .alu_out(alu_out1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
    .rsp_err(rsp_err1), .busy(busy1), .ops_count(ops_count1));

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, b);
    case (op)
      4'b1000: return a & b;
      4'b1001: return a | b;
      4'b1010: return ~(a & b);
      4'b1011: return ~(a | b);
      4'b1100: return ~a;
      4'b1101: return a ^ b;
      default: return 16'h0;
    endcase
  endfunction

  // behavioural ALUs: one registered stage for u0, three for u1
  always @(posedge clk) begin
    alu_out <= alu_f(alu_opcode, alu_a, alu_b);
    p0 <= alu_f(alu_opcode1, alu_a1, alu_b1);
    p1 <= p0;
    alu_out1 <= p1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    req_opcode = op; req_a = a; req_b = b; req_valid = 1;
    check("req_ready_before_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int k);
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic take;
    @(negedge clk);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("reset_req_ready", req_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_ops_count", ops_count, 0);
    check("reset_rsp_valid", rsp_valid, 0);

    send(4'b1000, 16'h0F0F, 16'h00FF);
    check("and_alu_opcode", alu_opcode, 4'b1000);
    check("and_busy", busy, 1);
    wait_rsp(n);
    check("and_latency", n, 2);
    check("and_data", rsp_data, 16'h000F);
    check("and_err", rsp_err, 0);
    check("and_alu_opcode_held", alu_opcode, 4'b1000);
    take;
    check("and_ops_count", ops_count, 1);
    check("and_idle", busy, 0);

    send(4'b1100, 16'h1234, 16'h0000);
    wait_rsp(n);
    check("not_latency", n, 2);
    req_opcode = 4'b1001; req_a = 16'h5555; req_b = 16'h0001; req_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("not_bp_data", rsp_data, 16'hEDCB);
      check("not_bp_valid", rsp_valid, 1);
      check("not_bp_req_ready", req_ready, 0);
    end
    check("not_second_not_accepted", alu_a, 16'h1234);
    req_valid = 0;
    take;
    check("not_ops_count", ops_count, 2);

    send(4'b0011, 16'hAAAA, 16'h5555);
    check("ill_alu_opcode", alu_opcode, 0);
    check("ill_alu_a", alu_a, 0);
    wait_rsp(n);
    check("ill_latency", n, 0);
    check("ill_err", rsp_err, 1);
    check("ill_data", rsp_data, 0);
    take;
    check("ill_ops_count", ops_count, 3);

    send(4'b1001, 16'h00F0, 16'h0F00);
    @(negedge clk);
    rst = 1;
    #1;
    check("wait_rst_busy", busy, 0);
    check("wait_rst_ops_count", ops_count, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("wait_rst_no_rsp", rsp_valid, 0);
    end

    send(4'b1101, 16'hFFFF, 16'h00F0);
    wait_rsp(n);
    check("xor_latency", n, 2);
    check("xor_data", rsp_data, 16'hFF0F);

    @(negedge clk);
    #2 rst = 1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_rsp_data", rsp_data, 0);
    check("midrst_rsp_err", rsp_err, 0);
    check("midrst_alu_opcode", alu_opcode, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_alu_b", alu_b, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 0;
    #1;
    check("midrst_req_ready", req_ready, 1);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] ops [4];
      logic [15:0] exp [4];
      ops = '{4'b1000, 4'b1001, 4'b1010, 4'b1011};
      exp = '{16'h0C50, 16'h3FFA, 16'hF3AF, 16'hC005};
      @(negedge clk);
      req_opcode1 = ops[i]; req_a1 = 16'h3C5A; req_b1 = 16'h0FF0; req_valid1 = 1;
      check("wrap_req_ready", req_ready1, 1);
      @(posedge clk); #1;
      req_valid1 = 0;
      n = 0;
      while (!rsp_valid1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      check("wrap_latency", n, 4);
      check("wrap_data", rsp_data1, exp[i]);
      @(negedge clk);
      rsp_ready1 = 1;
      @(posedge clk); #1;
      rsp_ready1 = 0;
      check("wrap_ops_count", ops_count1, (i + 1) % 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
